ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver that replaces the single-register keyboard front end. It filters the PS/2 clock, checks start, parity and stop bits, times out stalled frames, and queues accepted bytes in a show-ahead FIFO with a valid/ready output. The block sits between the PS2_CLK/PS2_DAT pins and the keyboard consumer, so the consumer can stall without losing scan codes.

## Interface
Parameters:
- CLOCK_SPEED, 8333333: system clock frequency in Hz.
- FIFO_DEPTH, 8: number of entries; power of two, ≥2.
- FILTER_LEN, 4: number of consecutive equal synchronised samples required before the filtered PS2_CLK changes; ≥1.
- TIMEOUT_CYCLES, CLOCK_SPEED/5000: number of high cycles of the filtered clock mid-frame before the frame is aborted (200 µs).

Ports:
- clk  in  1  system clock; the block has one clock.
- rst  in  1  reset, synchronous, active-high.
- PS2_CLK  in  1  raw PS/2 clock pin.
- PS2_DAT  in  1  raw PS/2 data pin.
- code_data  out  8  byte at the FIFO head.
- code_extended  out  1  head byte was preceded by E0 (macro only; otherwise 0).
- code_release  out  1  head byte was preceded by F0 (macro only; otherwise 0).
- code_valid  out  1  FIFO not empty.
- code_ready  in  1  consumer accepts the head entry.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- parity_err  out  1  one-cycle pulse: parity check failed.
- frame_err  out  1  one-cycle pulse: bad stop bit or timeout.
- overflow  out  1  one-cycle pulse: accepted byte dropped because the FIFO was full.

## Operation
- Input path: both pins pass through a 2-FF synchroniser. The synchronised PS2_CLK feeds a counter filter, which reset initialises to high. A falling edge (fall) is a one-cycle strobe when the filtered clock goes 1→0.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on fall, except the timeout.
  - IDLE: if sync data = 0, go to DATA and set bitcnt=0. If sync data = 1, stay in IDLE with no error.
  - DATA: shift data into bit bitcnt (LSB first) and increment bitcnt. After the 8th bit, go to PARITY.
  - PARITY: latch the bit, then go to STOP. The check is odd parity: the XOR of the 8 data bits and the parity bit must equal 1.
  - STOP: always go to IDLE.
    - data = 0: frame_err pulse.
    - data = 1 and parity bad: parity_err pulse.
    - both good: the byte is accepted.
- Timeout: in any state other than IDLE, a counter counts cycles while the filtered clock is high and clears on any fall. At TIMEOUT_CYCLES the block pulses frame_err, returns to IDLE and discards the partial byte.
- Error precedence: a bad stop bit reports frame_err only, never parity_err as well. Every error discards the byte.
- FIFO: show-ahead; code_data, code_extended and code_release are valid whenever code_valid=1.
  - A pop occurs when code_valid & code_ready. If code_valid=0, code_ready is ignored.
  - Write into a full FIFO: if a pop occurs in the same cycle, the write is accepted. Otherwise the byte is dropped, overflow pulses and the contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count ranges from 0 to FIFO_DEPTH.
- Reset, including mid-frame: FSM goes to IDLE, bitcnt=0, timeout counter=0, FIFO empty, prefix flags cleared.
  - Every output is 0 after reset: code_data=0, code_valid=0, fifo_count=0, all pulses 0.

## Timing
- Pin to fall: 2 sync cycles plus FILTER_LEN filter cycles.
- Accepted byte: the STOP fall is at cycle N. The write happens at N+1, and code_valid and fifo_count update at N+1.
- Error pulses assert at N+1 for exactly one cycle.
- Pop: fifo_count decrements, and the next entry appears on code_data in the cycle after the pop edge.
- Simultaneous push and pop: fifo_count is unchanged.

## Configuration
- PS2_PREFIX_DECODE_EN defined:
  - An accepted E0 sets ext_pending and an accepted F0 sets rel_pending. Neither prefix byte is enqueued.
  - The next accepted non-prefix byte is enqueued together with both flags, which then clear.
  - Any parity_err or frame_err clears both flags.
  - FIFO entries are 10 bits wide.
- PS2_PREFIX_DECODE_EN undefined:
  - Every accepted byte, including E0 and F0, is enqueued.
  - FIFO entries are 8 bits wide.
  - code_extended and code_release are tied to 0.

## Test plan
- Send 0x1C with odd parity correct and code_ready=0 → code_valid=1, code_data=0x1C, fifo_count=1, no error pulses.
- Send 0x1C with the parity bit inverted → one parity_err pulse, fifo_count stays 0. Send 0x1C with the stop bit = 0 → one frame_err pulse only.
- Send start + 4 bits, then hold the clock high for TIMEOUT_CYCLES → one frame_err pulse, FSM in IDLE. A following valid 0x32 frame is received as 0x32.
- FIFO_DEPTH=4, code_ready=0, send 5 bytes 0x01..0x05 → fifo_count=4, overflow pulses on the 5th byte. Pop order is 0x01..0x04.
- With the macro defined, send E0,F0,0x74 → a single entry: code_data=0x74, code_extended=1, code_release=1. Without the macro → three entries E0, F0, 74.
- Assert rst mid-DATA with 2 entries queued → next cycle code_valid=0 and fifo_count=0. A following 0x1C frame is received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with pin synchroniser, clock filter, frame checking,
// stall timeout and a show-ahead FIFO. Define PS2_PREFIX_DECODE_EN to fold E0/F0 prefixes into flags.
module ps2_rx_fifo #(
  parameter int unsigned CLOCK_SPEED    = 8333333,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = CLOCK_SPEED / 5000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DAT,
  output logic [7:0]                    code_data,
  output logic                          code_extended,
  output logic                          code_release,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef PS2_PREFIX_DECODE_EN
  localparam int unsigned ENTRY_W = 10;
`else
  localparam int unsigned ENTRY_W = 8;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic             clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic             filt_q, filt_d, fall_q, fall_d;
  logic [FLT_W-1:0] fcnt_q, fcnt_d;

  state_t           state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             to_fire_c, accept_c, perr_c, ferr_c;

  logic               push_c;
  logic [ENTRY_W-1:0] push_data_c;

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pop_c, full_c, wr_c, ovf_c;
  logic               parity_err_q, frame_err_q, overflow_q;
  logic [ENTRY_W-1:0] head_c;

  // Synchroniser, clock filter and registered fall strobe; pins idle high
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      fall_q     <= 1'b0;
    end else begin
      clk_meta_q <= PS2_CLK;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= PS2_DAT;
      dat_sync_q <= dat_meta_q;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      fall_q     <= fall_d;
    end
  end

  // Filtered clock flips after FILTER_LEN consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (fcnt_q == FLT_W'(FILTER_LEN - 1)) filt_d = clk_sync_q;
      else                                  fcnt_d = fcnt_q + FLT_W'(1);
    end
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      to_q     <= to_d;
    end
  end

  // Frame FSM; the stall timeout overrides any fall handling
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_d      = to_q;
    to_fire_c = 1'b0;
    accept_c  = 1'b0;
    perr_c    = 1'b0;
    ferr_c    = 1'b0;

    if (state_q == IDLE || fall_q) begin
      to_d = '0;
    end else if (filt_q) begin
      if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) to_fire_c = 1'b1;
      else                                    to_d = to_q + TO_W'(1);
    end

    if (to_fire_c) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      shift_d  = '0;
      to_d     = '0;
      ferr_c   = 1'b1;
    end else if (fall_q) begin
      unique case (state_q)
        IDLE: begin
          if (!dat_sync_q) begin
            state_d  = DATA;
            bitcnt_d = '0;
            shift_d  = '0;
          end
        end
        DATA: begin
          shift_d[bitcnt_q] = dat_sync_q;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_sync_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat_sync_q)                 ferr_c   = 1'b1;
          else if (!((^shift_q) ^ par_q))  perr_c   = 1'b1;
          else                             accept_c = 1'b1;
        end
      endcase
    end
  end

`ifdef PS2_PREFIX_DECODE_EN
  logic ext_q, ext_d, rel_q, rel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      rel_q <= rel_d;
    end
  end

  // Prefix bytes only arm flags; the next real byte carries them into the FIFO
  always_comb begin
    ext_d       = ext_q;
    rel_d       = rel_q;
    push_c      = 1'b0;
    push_data_c = {ext_q, rel_q, shift_q};
    if (accept_c) begin
      if (shift_q == 8'hE0)      ext_d = 1'b1;
      else if (shift_q == 8'hF0) rel_d = 1'b1;
      else begin
        push_c = 1'b1;
        ext_d  = 1'b0;
        rel_d  = 1'b0;
      end
    end
    if (perr_c || ferr_c) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end
  end

  assign code_extended = head_c[9];
  assign code_release  = head_c[8];
`else
  always_comb begin
    push_c      = accept_c;
    push_data_c = shift_q;
  end

  assign code_extended = 1'b0;
  assign code_release  = 1'b0;
`endif

  // A write into a full FIFO survives only if the head leaves in the same cycle
  always_comb begin
    pop_c    = (count_q != '0) && code_ready;
    full_c   = (count_q == CNT_W'(FIFO_DEPTH));
    wr_c     = push_c && (!full_c || pop_c);
    ovf_c    = push_c && full_c && !pop_c;
    wr_ptr_d = wr_c  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({wr_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    head_c = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (wr_c) mem_q[wr_ptr_q] <= push_data_c;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      parity_err_q <= perr_c;
      frame_err_q  <= ferr_c;
      overflow_q   <= ovf_c;
    end
  end

  assign code_data  = head_c[7:0];
  assign code_valid = (count_q != '0);
  assign fifo_count = count_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames are bit-banged on the pins and a queue model
// of accepted bytes and error counts is compared against the outputs every settled cycle.
module tb_ps2_rx_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned FLT   = 4;
  localparam int unsigned TO    = 200;
  localparam int unsigned H     = 25;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ps2_clk = 1'b1;
  logic          ps2_dat = 1'b1;
  logic          code_ready = 1'b0;
  logic [7:0]    code_data;
  logic          code_extended, code_release, code_valid;
  logic [CW-1:0] fifo_count;
  logic          parity_err, frame_err, overflow;

  ps2_rx_fifo #(
    .CLOCK_SPEED   (1000000),
    .FIFO_DEPTH    (DEPTH),
    .FILTER_LEN    (FLT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .PS2_CLK      (ps2_clk),
    .PS2_DAT      (ps2_dat),
    .code_data    (code_data),
    .code_extended(code_extended),
    .code_release (code_release),
    .code_valid   (code_valid),
    .code_ready   (code_ready),
    .fifo_count   (fifo_count),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
  int obs_perr = 0, obs_ferr = 0, obs_ovf = 0;
  bit chk_en = 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
  bit ext_pend = 1'b0;
  bit rel_pend = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the receiver must hold after each complete frame
  task automatic model_clear_prefix();
`ifdef PS2_PREFIX_DECODE_EN
    ext_pend = 1'b0;
    rel_pend = 1'b0;
`endif
  endtask

  task automatic model_push(input logic [9:0] e);
    if (exp_q.size() == DEPTH) exp_ovf++;
    else exp_q.push_back(e);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    if (stop_bad) begin
      exp_ferr++;
      model_clear_prefix();
    end else if (par_bad) begin
      exp_perr++;
      model_clear_prefix();
    end else begin
`ifdef PS2_PREFIX_DECODE_EN
      if (b == 8'hE0) ext_pend = 1'b1;
      else if (b == 8'hF0) rel_pend = 1'b1;
      else begin
        model_push({ext_pend, rel_pend, b});
        model_clear_prefix();
      end
`else
      model_push({2'b00, b});
`endif
    end
  endtask

  // Pulse counters and per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (parity_err === 1'b1) obs_perr++;
    if (frame_err === 1'b1)  obs_ferr++;
    if (overflow === 1'b1)   obs_ovf++;
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("code_valid", code_valid, exp_q.size() != 0);
      check("fifo_count", fifo_count, exp_q.size());
      if (exp_q.size() != 0) begin
        check("code_data", code_data, exp_q[0][7:0]);
        check("code_extended", code_extended, exp_q[0][9]);
        check("code_release", code_release, exp_q[0][8]);
      end
      check("parity_err_pulses", obs_perr, exp_perr);
      check("frame_err_pulses", obs_ferr, exp_ferr);
      check("overflow_pulses", obs_ovf, exp_ovf);
    end
  end

  // One PS/2 bit: data set while clock high, then a low half-period
  task automatic drive_bit(input logic b, input bit lat);
    ps2_dat = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= int'(H); i++) begin
      @(posedge clk);
      #1;
      if (lat && i == 6) check("latency_before_write", code_valid, 1'b0);
      if (lat && i == 7) check("latency_at_write", code_valid, 1'b1);
    end
    @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad, input bit lat);
    logic p;
    chk_en = 1'b0;
    p = ~(^b) ^ par_bad;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 1'b0);
    drive_bit(p, 1'b0);
    drive_bit(~stop_bad, lat);
    ps2_dat = 1'b1;
    repeat (20) @(negedge clk);
    model_frame(b, par_bad, stop_bad);
    chk_en = 1'b1;
  endtask

  task automatic partial_frame(input int nbits);
    chk_en = 1'b0;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(i[0], 1'b0);
    ps2_dat = 1'b1;
  endtask

  task automatic pop_one(input bit has_lit, input logic [9:0] lit);
    @(negedge clk);
    if (has_lit) begin
      check("pop_head_data", code_data, lit[7:0]);
      check("pop_head_ext", code_extended, lit[9]);
      check("pop_head_rel", code_release, lit[8]);
    end
    code_ready = 1'b1;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    code_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_code_data", code_data, 8'h00);
    check("rst_code_valid", code_valid, 1'b0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_pulses", {parity_err, frame_err, overflow}, 3'b000);
    check("rst_prefix", {code_extended, code_release}, 2'b00);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk_en = 1'b1;

    // Good byte, exact write latency after the stop-bit fall
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
    check("lit_1c_data", code_data, 8'h1C);
    check("lit_1c_count", fifo_count, 1);
    check("lit_1c_no_err", obs_perr + obs_ferr + obs_ovf, 0);
    pop_one(1'b1, 10'h01C);

    // Parity and stop-bit errors
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check("lit_parity_pulse", obs_perr, 1);
    check("lit_parity_count", fifo_count, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("lit_stop_frame_pulse", obs_ferr, 1);
    check("lit_stop_no_parity", obs_perr, 1);

    // Stalled frame times out, next frame still decodes
    partial_frame(4);
    repeat (TO + 40) @(negedge clk);
    exp_ferr++;
    model_clear_prefix();
    chk_en = 1'b1;
    check("lit_timeout_pulse", obs_ferr, 2);
    send_frame(8'h32, 1'b0, 1'b0, 1'b0);
    pop_one(1'b1, 10'h032);

    // Fill past depth
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
    check("lit_full_count", fifo_count, 4);
    check("lit_overflow_pulse", obs_ovf, 1);
    for (int i = 1; i <= 4; i++) pop_one(1'b1, 10'(i));
    check("lit_drained", code_valid, 1'b0);

    // Prefix sequences
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0, 1'b0);
`ifdef PS2_PREFIX_DECODE_EN
    check("lit_prefix_count", fifo_count, 1);
    pop_one(1'b1, 10'h374);
`else
    check("lit_prefix_count", fifo_count, 3);
    pop_one(1'b1, 10'h0E0);
    pop_one(1'b1, 10'h0F0);
    pop_one(1'b1, 10'h074);
`endif
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0);
`ifdef PS2_PREFIX_DECODE_EN
    pop_one(1'b1, 10'h012);
`else
    pop_one(1'b1, 10'h0E0);
    pop_one(1'b1, 10'h012);
`endif
    while (exp_q.size() != 0) pop_one(1'b0, 10'h000);

    // Reset mid-DATA with entries queued
    send_frame(8'h10, 1'b0, 1'b0, 1'b0);
    send_frame(8'h20, 1'b0, 1'b0, 1'b0);
    partial_frame(3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("lit_midrst_valid", code_valid, 1'b0);
    check("lit_midrst_count", fifo_count, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_clear_prefix();
    repeat (20) @(negedge clk);
    chk_en = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    pop_one(1'b1, 10'h01C);

    // Ready while empty is ignored
    code_ready = 1'b1;
    repeat (5) @(negedge clk);
    code_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("lit_empty_ready_count", fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
